drive_sequencer: RTL and testbench

Command-level controller that sequences the drive-train motor PWM stage. Accepts direction/speed commands via a valid/ready handshake and ramps a speed level toward the target. On reversal or stop it decelerates to zero and inserts a dead interval before re-energising. Its `DutyCycle` output drives the MotorPWM channel-enable input directly; `level` feeds the variable-duty PWM path.

---
 rtl/drive_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_drive_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drive_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : drive_sequencer
//  Purpose  : Command-level controller for the drive-train motor PWM stage.
//             Accepts direction/speed commands over a valid/ready handshake,
//             ramps the speed level toward the target, and on reversal or
//             stop decelerates to zero and holds a dead interval before
//             re-energising in the new direction.
//  Ports    : clk        - system clock, rising edge
//             reset      - synchronous active-high reset
//             cmd_valid  - command present
//             cmd_ready  - command accepted when cmd_valid && cmd_ready
//             cmd_dir    - 00 stop, 10 forward, 01 reverse, 11 illegal
//             cmd_level  - target speed level
//             DutyCycle  - MotorPWM enables: [1] channel A fwd, [0] channel B rev
//             level      - current speed level
//             busy       - high while ramping, decelerating or dead
//             err        - sticky, set when an illegal direction is accepted
//  Config   : DRIVE_BRAKE_EN - when defined, the dead interval drives both
//             channels (active brake); otherwise both are released (coast).
//  Revision : 1.0 - initial release
// ============================================================================
module drive_sequencer #(
  parameter int LEVEL_W     = 8,
  parameter int RAMP_DIV    = 1000,
  parameter int RAMP_STEP   = 1,
  parameter int DEAD_CYCLES = 5000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_dir,
  input  logic [LEVEL_W-1:0] cmd_level,
  output logic [1:0]         DutyCycle,
  output logic [LEVEL_W-1:0] level,
  output logic               busy,
  output logic               err
);

  localparam int C_PRESC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int C_DEAD_W  = $clog2(DEAD_CYCLES + 1);

  localparam logic [C_PRESC_W-1:0] C_PRESC_MAX = C_PRESC_W'(RAMP_DIV - 1);
  localparam logic [C_DEAD_W-1:0]  C_DEAD_MAX  = C_DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [LEVEL_W-1:0]   C_STEP      = LEVEL_W'(RAMP_STEP);
  localparam logic [1:0]           C_DIR_STOP    = 2'b00;
  localparam logic [1:0]           C_DIR_ILLEGAL = 2'b11;

`ifdef DRIVE_BRAKE_EN
  localparam logic [1:0] C_DEAD_DUTY = 2'b11;
`else
  localparam logic [1:0] C_DEAD_DUTY = 2'b00;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RAMP  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DECEL = 3'd3,
    ST_DEAD  = 3'd4
  } state_t;

  state_t               state_q,     state_d;
  logic [LEVEL_W-1:0]   level_q,     level_d;
  logic [1:0]           duty_q,      duty_d;
  logic [1:0]           cur_dir_q,   cur_dir_d;
  logic [1:0]           tgt_dir_q,   tgt_dir_d;
  logic [LEVEL_W-1:0]   tgt_level_q, tgt_level_d;
  logic [C_PRESC_W-1:0] presc_q,     presc_d;
  logic [C_DEAD_W-1:0]  dead_cnt_q,  dead_cnt_d;
  logic                 err_q,       err_d;
  logic                 ready_q,     ready_d;
  logic                 busy_q,      busy_d;

  logic                 accept;
  logic                 tick;
  logic                 step;
  logic [1:0]           eff_dir;
  logic [LEVEL_W-1:0]   eff_level;
  logic [LEVEL_W-1:0]   toward_lvl;
  logic [LEVEL_W-1:0]   decel_lvl;
  logic [LEVEL_W-1:0]   ramp_lvl;
  logic [LEVEL_W-1:0]   dec_lvl;

  always_comb begin
    accept = cmd_valid && ready_q;
    tick   = (presc_q == C_PRESC_MAX);
    // An accepted command restarts the prescaler, so it suppresses the step.
    step   = tick && !accept;

    // Decisions on the accepting edge already see the new target.
    eff_dir   = accept ? ((cmd_dir == C_DIR_ILLEGAL) ? C_DIR_STOP : cmd_dir) : tgt_dir_q;
    eff_level = accept ? cmd_level : tgt_level_q;

    // One step toward the target; snap to it when closer than a full step.
    // The distance test guards against overshoot and wrap at both ends.
    toward_lvl = level_q;
    if (level_q < eff_level) begin
      toward_lvl = ((eff_level - level_q) < C_STEP) ? eff_level : level_q + C_STEP;
    end else if (level_q > eff_level) begin
      toward_lvl = ((level_q - eff_level) < C_STEP) ? eff_level : level_q - C_STEP;
    end
    decel_lvl = (level_q < C_STEP) ? '0 : level_q - C_STEP;
    ramp_lvl  = step ? toward_lvl : level_q;
    dec_lvl   = step ? decel_lvl  : level_q;

    state_d     = state_q;
    level_d     = level_q;
    cur_dir_d   = cur_dir_q;
    tgt_dir_d   = eff_dir;
    tgt_level_d = eff_level;
    presc_d     = (accept || tick) ? '0 : presc_q + 1'b1;
    err_d       = err_q || (accept && (cmd_dir == C_DIR_ILLEGAL));
    dead_cnt_d  = '0;

    case (state_q)
      ST_IDLE: begin
        level_d = '0;
        if (accept && (eff_dir != C_DIR_STOP) && (eff_level != '0)) begin
          cur_dir_d = eff_dir;
          state_d   = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (eff_dir != cur_dir_q) begin
          state_d = ST_DECEL;
        end else begin
          level_d = ramp_lvl;
          if (ramp_lvl == eff_level) begin
            state_d = (eff_level != '0) ? ST_HOLD : ST_DEAD;
          end
        end
      end
      ST_HOLD: begin
        if (eff_dir != cur_dir_q) begin
          state_d = ST_DECEL;
        end else if (eff_level != level_q) begin
          state_d = ST_RAMP;
        end
      end
      ST_DECEL: begin
        level_d = dec_lvl;
        if (dec_lvl == '0) begin
          state_d = ST_DEAD;
        end
      end
      ST_DEAD: begin
        level_d    = '0;
        dead_cnt_d = dead_cnt_q + 1'b1;
        if (dead_cnt_q == C_DEAD_MAX) begin
          dead_cnt_d = '0;
          // No command can be accepted in DEAD, so the registered target is current.
          if ((tgt_dir_q == C_DIR_STOP) || (tgt_level_q == '0)) begin
            state_d = ST_IDLE;
          end else begin
            cur_dir_d = tgt_dir_q;
            state_d   = ST_RAMP;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        level_d = '0;
      end
    endcase

    // Outputs are registered, derived from the state being entered so that
    // they change on the same edge as the state itself.
    duty_d  = cur_dir_d;
    busy_d  = 1'b0;
    ready_d = 1'b1;
    case (state_d)
      ST_IDLE: begin
        duty_d = 2'b00;
      end
      ST_RAMP, ST_DECEL: begin
        busy_d = 1'b1;
      end
      ST_DEAD: begin
        duty_d  = C_DEAD_DUTY;
        busy_d  = 1'b1;
        ready_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      level_q     <= '0;
      duty_q      <= 2'b00;
      cur_dir_q   <= 2'b00;
      tgt_dir_q   <= 2'b00;
      tgt_level_q <= '0;
      presc_q     <= '0;
      dead_cnt_q  <= '0;
      err_q       <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      duty_q      <= duty_d;
      cur_dir_q   <= cur_dir_d;
      tgt_dir_q   <= tgt_dir_d;
      tgt_level_q <= tgt_level_d;
      presc_q     <= presc_d;
      dead_cnt_q  <= dead_cnt_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign DutyCycle = duty_q;
  assign level     = level_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign cmd_ready = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_drive_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_drive_sequencer
//  Purpose  : Self-checking bench for drive_sequencer. A vector table covers
//             reset, forward ramp and reversal; short hand-written sequences
//             cover clamping, illegal direction and reset during a ramp; a
//             random phase is compared every cycle against a behavioural model.
//  Config   : DRIVE_BRAKE_EN selects the expected dead-interval enables.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_drive_sequencer;

  localparam int LEVEL_W     = 8;
  localparam int RAMP_DIV    = 4;
  localparam int RAMP_STEP   = 16;
  localparam int DEAD_CYCLES = 8;
`ifdef DRIVE_BRAKE_EN
  localparam int DEAD_DUTY = 3;
`else
  localparam int DEAD_DUTY = 0;
`endif
  localparam int FWD = 2;
  localparam int REV = 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_dir = 2'b00;
  logic [LEVEL_W-1:0] cmd_level = '0;
  logic [1:0]         DutyCycle;
  logic [LEVEL_W-1:0] level;
  logic               busy;
  logic               err;

  int n_checks = 0;
  int n_fail   = 0;

  drive_sequencer #(
    .LEVEL_W    (LEVEL_W),
    .RAMP_DIV   (RAMP_DIV),
    .RAMP_STEP  (RAMP_STEP),
    .DEAD_CYCLES(DEAD_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dir  (cmd_dir),
    .cmd_level(cmd_level),
    .DutyCycle(DutyCycle),
    .level    (level),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no summary, required completion");
    $fatal(1);
  end

  // ---------------------------------------------------------------- checker
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  // Behavioural reference: drive phases, a countdown for the dead interval,
  // and plain integer arithmetic for the level approach.
  localparam int M_IDLE = 0, M_RAMP = 1, M_HOLD = 2, M_DECEL = 3, M_DEAD = 4;
  int m_mode = M_IDLE;
  int m_lvl = 0, m_tdir = 0, m_tlvl = 0, m_cdir = 0;
  int m_presc = 0, m_dead_left = 0, m_err = 0;

  task automatic model_clock();
    bit acc, tick, move;
    int diff;
    if (reset) begin
      m_mode = M_IDLE; m_lvl = 0; m_tdir = 0; m_tlvl = 0; m_cdir = 0;
      m_presc = 0; m_dead_left = 0; m_err = 0;
      return;
    end
    acc  = cmd_valid && (m_mode != M_DEAD);
    tick = (m_presc == RAMP_DIV - 1);
    move = tick && !acc;
    m_presc = acc ? 0 : (m_presc + 1) % RAMP_DIV;
    if (acc) begin
      m_tdir = (cmd_dir == 2'b11) ? 0 : int'(cmd_dir);
      m_tlvl = int'(cmd_level);
      if (cmd_dir == 2'b11) m_err = 1;
    end
    case (m_mode)
      M_IDLE: if (acc && m_tdir != 0 && m_tlvl > 0) begin
        m_cdir = m_tdir; m_mode = M_RAMP;
      end
      M_RAMP: begin
        if (m_tdir != m_cdir) m_mode = M_DECEL;
        else begin
          if (move) begin
            diff = m_tlvl - m_lvl;
            if (diff > -RAMP_STEP && diff < RAMP_STEP) m_lvl = m_tlvl;
            else m_lvl = m_lvl + ((diff > 0) ? RAMP_STEP : -RAMP_STEP);
          end
          if (m_lvl == m_tlvl) begin
            if (m_tlvl > 0) m_mode = M_HOLD;
            else begin m_mode = M_DEAD; m_dead_left = DEAD_CYCLES; end
          end
        end
      end
      M_HOLD: begin
        if (m_tdir != m_cdir) m_mode = M_DECEL;
        else if (m_tlvl != m_lvl) m_mode = M_RAMP;
      end
      M_DECEL: begin
        if (move) m_lvl = (m_lvl > RAMP_STEP) ? m_lvl - RAMP_STEP : 0;
        if (m_lvl == 0) begin m_mode = M_DEAD; m_dead_left = DEAD_CYCLES; end
      end
      default: begin
        m_dead_left--;
        if (m_dead_left == 0) begin
          if (m_tdir == 0 || m_tlvl == 0) m_mode = M_IDLE;
          else begin m_cdir = m_tdir; m_mode = M_RAMP; end
        end
      end
    endcase
  endtask

  function automatic int model_duty();
    if (m_mode == M_IDLE) return 0;
    if (m_mode == M_DEAD) return DEAD_DUTY;
    return m_cdir;
  endfunction

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    chk("model_duty",  32'(DutyCycle), 32'(model_duty()));
    chk("model_level", 32'(level),     32'(m_lvl));
    chk("model_ready", 32'(cmd_ready), (m_mode != M_DEAD) ? 32'd1 : 32'd0);
    chk("model_busy",  32'(busy),      (m_mode == M_RAMP || m_mode == M_DECEL || m_mode == M_DEAD) ? 32'd1 : 32'd0);
    chk("model_err",   32'(err),       32'(m_err));
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send(input int dir, input int lvl);
    cmd_valid = 1'b1; cmd_dir = 2'(dir); cmd_level = 8'(lvl);
    cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; cmd_valid = 1'b0;
    cycle(); cycle();
    reset = 1'b0;
  endtask

  task automatic outs(input string tag, input int d, input int l, input int r, input int b, input int e);
    chk({tag, "_duty"},  32'(DutyCycle), 32'(d));
    chk({tag, "_level"}, 32'(level),     32'(l));
    chk({tag, "_ready"}, 32'(cmd_ready), 32'(r));
    chk({tag, "_busy"},  32'(busy),      32'(b));
    chk({tag, "_err"},   32'(err),       32'(e));
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    bit        rst;
    bit        vld;
    bit [1:0]  dir;
    bit [7:0]  lvl;
    bit [1:0]  e_duty;
    bit [7:0]  e_level;
    bit        e_rdy;
    bit        e_busy;
    bit        e_err;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(int rst, int vld, int dir, int lvl,
                              int ed, int el, int er, int eb, int ee);
    vec_t v;
    v.rst = 1'(rst); v.vld = 1'(vld); v.dir = 2'(dir); v.lvl = 8'(lvl);
    v.e_duty = 2'(ed); v.e_level = 8'(el); v.e_rdy = 1'(er); v.e_busy = 1'(eb); v.e_err = 1'(ee);
    tbl.push_back(v);
  endfunction

  initial begin
    // Reset held three cycles, then one quiet cycle.
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // Forward 64: enables next cycle, one 16-step every 4 cycles, HOLD at 64.
    add(0, 1, FWD, 64, FWD, 0, 1, 1, 0);
    for (int k = 1; k <= 16; k++) add(0, 0, 0, 0, FWD, 16 * (k / 4), 1, (k < 16) ? 1 : 0, 0);
    add(0, 0, 0, 0, FWD, 64, 1, 0, 0);
    add(0, 0, 0, 0, FWD, 64, 1, 0, 0);
    // Reverse 32 from HOLD: decel to 0, dead interval, then ramp reverse.
    add(0, 1, REV, 32, FWD, 64, 1, 1, 0);
    for (int k = 1; k < 16; k++) add(0, 0, 0, 0, FWD, 64 - 16 * (k / 4), 1, 1, 0);
    for (int k = 16; k < 24; k++) add(0, 0, 0, 0, DEAD_DUTY, 0, 0, 1, 0);
    for (int k = 24; k < 34; k++)
      add(0, 0, 0, 0, REV, (k < 28) ? 0 : ((k < 32) ? 16 : 32), 1, (k < 32) ? 1 : 0, 0);

    @(negedge clk);
    foreach (tbl[i]) begin
      reset = tbl[i].rst; cmd_valid = tbl[i].vld; cmd_dir = tbl[i].dir; cmd_level = tbl[i].lvl;
      cycle();
      outs($sformatf("vec%0d", i), tbl[i].e_duty, tbl[i].e_level, tbl[i].e_rdy, tbl[i].e_busy, tbl[i].e_err);
    end
    cmd_valid = 1'b0;

    // Retarget downward within the same direction: 64 -> 48 -> 40 (clamped).
    do_reset();
    send(FWD, 64);
    idle(16);
    outs("clamp_hold64", FWD, 64, 1, 0, 0);
    send(FWD, 40);
    idle(4);
    outs("clamp_48", FWD, 48, 1, 1, 0);
    idle(4);
    outs("clamp_40", FWD, 40, 1, 0, 0);
    idle(3);
    outs("clamp_stay", FWD, 40, 1, 0, 0);

    // Illegal direction from HOLD 40: sticky err, decel 24, 8, 0, dead, idle.
    send(3, 99);
    outs("illegal_acc", FWD, 40, 1, 1, 1);
    idle(4);
    outs("illegal_24", FWD, 24, 1, 1, 1);
    idle(8);
    outs("illegal_dead", DEAD_DUTY, 0, 0, 1, 1);
    idle(7);
    outs("illegal_dead_end", DEAD_DUTY, 0, 0, 1, 1);
    idle(1);
    outs("illegal_idle", 0, 0, 1, 0, 1);
    idle(5);
    outs("illegal_sticky", 0, 0, 1, 0, 1);

    // Reset mid-ramp at level 32, with a concurrent command that must be ignored.
    do_reset();
    send(FWD, 64);
    idle(8);
    outs("mid_ramp32", FWD, 32, 1, 1, 0);
    reset = 1'b1; cmd_valid = 1'b1; cmd_dir = 2'(REV); cmd_level = 8'd100;
    cycle();
    outs("rst_override", 0, 0, 1, 0, 0);
    reset = 1'b0; cmd_valid = 1'b0;
    cycle();
    outs("rst_after", 0, 0, 1, 0, 0);

    // Random commands against the model.
    for (int i = 0; i < 2500; i++) begin
      int r;
      reset     = ($urandom_range(0, 199) == 0);
      cmd_valid = ($urandom_range(0, 11) == 0);
      r = $urandom_range(0, 15);
      cmd_dir   = (r == 0) ? 2'b11 : 2'(r % 3);
      case ($urandom_range(0, 3))
        0:       cmd_level = 8'd0;
        1:       cmd_level = 8'($urandom_range(1, 20));
        2:       cmd_level = 8'd255;
        default: cmd_level = 8'($urandom);
      endcase
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
